// File: rtl/quiz_pkg.sv
// rtl/quiz_pkg.sv - shared state encoding and 7-segment helper for the quiz buzzer
package quiz_pkg;

  typedef enum logic [1:0] {IDLE, ARMED, LOCKED, TIMEOUT} state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segments, bit order gfedcba; anything outside 0..9 is blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/quiz_countdown.sv
// rtl/quiz_countdown.sv - 1 s prescaler plus remaining-seconds counter for the quiz round
module quiz_countdown
  import quiz_pkg::*;
#(
  parameter int COUNT_SECS = 30,
  parameter int TICK_DIV   = 50000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic       enable,
  output logic [6:0] remaining,
  output logic       expire
);

  localparam int             PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [6:0]     SECS     = 7'(COUNT_SECS);

  logic [PW-1:0] prescaler;
  logic          wrap;

  assign wrap   = enable && (prescaler == PRE_LAST);
  assign expire = wrap && (remaining == 7'd1);

  always_ff @(posedge clock) begin
    if (reset || load) begin
      prescaler <= '0;
      remaining <= SECS;
    end else if (enable) begin
      if (wrap) begin
        prescaler <= '0;
        if (remaining != 7'd0) remaining <= remaining - 7'd1;
      end else begin
        prescaler <= prescaler + PW'(1);
      end
    end
  end

endmodule

// File: rtl/quiz_responder.sv
// rtl/quiz_responder.sv - N-player quiz buzzer top; define FALSE_START_EN for false-start disqualification
module quiz_responder
  import quiz_pkg::*;
#(
  parameter int NUM_PLAYERS = 3,
  parameter int COUNT_SECS  = 30,
  parameter int TICK_DIV    = 50000000,
  parameter int BEEP_CYCLES = 25000000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   clear,
  input  logic [NUM_PLAYERS-1:0] con,
  output logic [3:0]             winner,
  output logic                   winner_valid,
  output logic                   timeout,
  output logic [6:0]             bs0,
  output logic [6:0]             bs1,
  output logic                   beep
);

  localparam int             BW        = $clog2(BEEP_CYCLES + 1);
  localparam logic [BW-1:0]  BEEP_LOAD = BW'(BEEP_CYCLES);

  if (NUM_PLAYERS < 2 || NUM_PLAYERS > 9) begin : g_bad_players
    $error("quiz_responder: NUM_PLAYERS must be 2..9");
  end
  if (COUNT_SECS < 1 || COUNT_SECS > 99) begin : g_bad_secs
    $error("quiz_responder: COUNT_SECS must be 1..99");
  end
  if (TICK_DIV < 1) begin : g_bad_div
    $error("quiz_responder: TICK_DIV must be at least 1");
  end
  if (BEEP_CYCLES < 1) begin : g_bad_beep
    $error("quiz_responder: BEEP_CYCLES must be at least 1");
  end

  state_t                 state, state_next;
  logic [NUM_PLAYERS-1:0] con_q;
  logic [NUM_PLAYERS-1:0] press;
  logic [NUM_PLAYERS-1:0] live;
  logic [3:0]             pick;
  logic [BW-1:0]          beep_cnt;
  logic [6:0]             remaining;
  logic                   expire;
  logic                   cd_load;
  logic                   round_end;
  logic [3:0]             tens, ones;

  // Edge detect means a key already held when the round arms can never win.
  assign press = con & ~con_q;

`ifdef FALSE_START_EN
  logic [NUM_PLAYERS-1:0] dq;

  always_ff @(posedge clock) begin
    if (reset || clear) dq <= '0;
    else if (state == IDLE) dq <= dq | press;
  end

  assign live = press & ~dq;
`else
  assign live = press;
`endif

  always_comb begin
    pick = 4'd0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (live[i]) pick = 4'(i + 1);
    end
  end

  quiz_countdown #(
    .COUNT_SECS(COUNT_SECS),
    .TICK_DIV  (TICK_DIV)
  ) u_countdown (
    .clock    (clock),
    .reset    (reset),
    .load     (cd_load),
    .enable   (state == ARMED),
    .remaining(remaining),
    .expire   (expire)
  );

  always_comb begin
    state_next = state;
    cd_load    = 1'b0;
    if (clear) begin
      if (state != IDLE) begin
        state_next = IDLE;
        cd_load    = 1'b1;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_next = ARMED;
            cd_load    = 1'b1;
          end
        end
        // A press in the same cycle as the final tick still wins.
        ARMED: begin
          if (|live)       state_next = LOCKED;
          else if (expire) state_next = TIMEOUT;
        end
        default: ;
      endcase
    end
  end

  assign round_end = (state == ARMED) && (state_next != ARMED) && !clear;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      con_q    <= '0;
      winner   <= 4'd0;
      beep_cnt <= '0;
    end else begin
      state <= state_next;
      con_q <= con;
      if (clear) winner <= 4'd0;
      else if (state == ARMED && state_next == LOCKED) winner <= pick;
      if (clear) beep_cnt <= '0;
      else if (round_end) beep_cnt <= BEEP_LOAD;
      else if (beep_cnt != '0) beep_cnt <= beep_cnt - BW'(1);
    end
  end

  assign winner_valid = (state == LOCKED);
  assign timeout      = (state == TIMEOUT);
  assign beep         = (beep_cnt != '0);

  always_comb begin
    tens = 4'(remaining / 7'd10);
    ones = 4'(remaining % 7'd10);
    bs1  = seg7(tens);
    bs0  = seg7(ones);
    case (state)
      LOCKED: begin
        bs1 = SEG_BLANK;
        bs0 = seg7(winner);
      end
      TIMEOUT: begin
        bs1 = seg7(4'd0);
        bs0 = seg7(4'd0);
      end
      default: ;
    endcase
  end

endmodule
